seq_det_ctrl: RTL and testbench

//  Sequencer for the bit-serial sequence detector (z=1 after a run of four equal bits; Mealy output).

---
 rtl/seq_det_pkg.sv | 16 +
 rtl/seq_det_shreg.sv | 29 ++
 rtl/seq_det_ctrl.sv | 129 ++++++++++++
 tb/tb_seq_det_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types for the sequence-detector sequencer: one-hot FSM encoding
// and the result-width helper.
package seq_det_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_SHIFT = 3'b010,
        S_DONE  = 3'b100
    } state_t;

    // Bits needed to hold a count from 0 to width inclusive.
    function automatic int calc_cw(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_det_shreg.sv
// WIDTH-bit parallel-load, shift-left register; the MSB is the serial output.
module seq_det_shreg #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    output logic             msb
);

    logic [WIDTH-1:0] q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= data;
        end else if (shift) begin
            q <= {q[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = q[WIDTH-1];

endmodule

// File: rtl/seq_det_ctrl.sv
// Sequencer that feeds a parallel word MSB-first into the sequence detector and
// collects hit statistics. Define SEQ_DET_HIT_MASK_EN to build the per-bit hit mask.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter  int WIDTH = 10,
    localparam int CW    = calc_cw(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             done,
    output logic             det_rst,
    output logic             det_w,
    input  logic             det_z,
    output logic [CW-1:0]    hit_cnt,
    output logic             hit_any,
    output logic [CW-1:0]    first_idx,
    output logic [WIDTH-1:0] hit_mask
);

    state_t          state;
    state_t          next_state;
    logic   [CW-1:0] idx;
    logic            accept;
    logic            shifting;
    logic            last_bit;
    logic            ser_bit;

    assign accept   = (state == S_IDLE) && start;
    assign shifting = (state == S_SHIFT);
    assign last_bit = (idx == CW'(WIDTH - 1));

    seq_det_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (shifting),
        .data  (data),
        .msb   (ser_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: a default assignment ahead of the case keeps every path driven,
    // so no latch is inferred for next_state.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_SHIFT;
            S_SHIFT: if (last_bit) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        det_rst = 1'b1;
        det_w   = 1'b0;
        case (state)
            S_SHIFT: begin
                busy    = 1'b1;
                det_rst = 1'b0;
                det_w   = ser_bit;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Results clear on an accepted start and are otherwise held outside SHIFT.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            hit_cnt   <= '0;
            hit_any   <= 1'b0;
            first_idx <= '0;
        end else if (accept) begin
            idx       <= '0;
            hit_cnt   <= '0;
            hit_any   <= 1'b0;
            first_idx <= '0;
        end else if (shifting) begin
            idx <= idx + CW'(1);
            if (det_z) begin
                if (hit_cnt != CW'(WIDTH)) begin
                    hit_cnt <= hit_cnt + CW'(1);
                end
                if (!hit_any) begin
                    hit_any   <= 1'b1;
                    first_idx <= idx;
                end
            end
        end
    end

`ifdef SEQ_DET_HIT_MASK_EN
    logic [WIDTH-1:0] mask_q;

    // Mask starts cleared each run, so only hits need to set bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '0;
        end else if (accept) begin
            mask_q <= '0;
        end else if (shifting && det_z) begin
            mask_q <= mask_q | (WIDTH'(1) << idx);
        end
    end

    assign hit_mask = mask_q;
`else
    assign hit_mask = '0;
`endif

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl (WIDTH=8) with a behavioural four-equal-bits
// detector attached; honours SEQ_DET_HIT_MASK_EN when expecting hit_mask.
module tb_seq_det_ctrl;

    localparam int WIDTH = 8;
    localparam int CW    = 4;
`ifdef SEQ_DET_HIT_MASK_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] data;
    logic             busy;
    logic             done;
    logic             det_rst;
    logic             det_w;
    logic             det_z;
    logic [CW-1:0]    hit_cnt;
    logic             hit_any;
    logic [CW-1:0]    first_idx;
    logic [WIDTH-1:0] hit_mask;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_det_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .data      (data),
        .busy      (busy),
        .done      (done),
        .det_rst   (det_rst),
        .det_w     (det_w),
        .det_z     (det_z),
        .hit_cnt   (hit_cnt),
        .hit_any   (hit_any),
        .first_idx (first_idx),
        .hit_mask  (hit_mask)
    );

    // Detector: run length of equal bits (saturating at 4). After four 0s z=1
    // for any w; after four 1s z=1 only while w stays 1.
    logic [2:0] d_cnt;
    logic       d_last;

    always_ff @(posedge clk) begin
        if (det_rst) begin
            d_cnt  <= 3'd0;
            d_last <= 1'b0;
        end else if (d_cnt == 3'd0 || det_w != d_last) begin
            d_last <= det_w;
            d_cnt  <= 3'd1;
        end else if (d_cnt != 3'd4) begin
            d_cnt <= d_cnt + 3'd1;
        end
    end

    assign det_z = (d_cnt == 3'd4) && (!d_last || det_w);

    typedef struct {
        logic [7:0] word;
        int         e_cnt;
        int         e_any;
        int         e_first;
        logic [7:0] e_mask;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] mask_exp(input logic [7:0] m);
        return MASK_EN ? m : 8'h00;
    endfunction

    task automatic check_results(input string tag, input int e_cnt, input int e_any,
                                 input int e_first, input logic [7:0] e_mask);
        check({tag, " hit_cnt"},   32'(hit_cnt),   32'(e_cnt));
        check({tag, " hit_any"},   32'(hit_any),   32'(e_any));
        check({tag, " first_idx"}, 32'(first_idx), 32'(e_first));
        check({tag, " hit_mask"},  32'(hit_mask),  32'(mask_exp(e_mask)));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " busy"},    32'(busy),    32'd0);
        check({tag, " done"},    32'(done),    32'd0);
        check({tag, " det_rst"}, 32'(det_rst), 32'd1);
        check({tag, " det_w"},   32'(det_w),   32'd0);
        check_results(tag, 0, 0, 0, 8'h00);
    endtask

    // One start pulse from IDLE; checks serial bits, done latency and results.
    task automatic run_word(input string tag, input logic [7:0] word, input int e_cnt,
                            input int e_any, input int e_first, input logic [7:0] e_mask);
        int lat;
        bit seen;
        logic [7:0] w;
        w = word;
        @(negedge clk);
        start = 1'b1;
        data  = w;
        @(posedge clk);
        #1 start = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (lat < 20 && !seen) begin
            @(negedge clk);
            lat++;
            if (done) begin
                seen = 1'b1;
            end else if (lat <= WIDTH) begin
                check({tag, " det_w"}, 32'(det_w), 32'(w[WIDTH-lat]));
            end
        end
        check({tag, " done latency"}, 32'(lat), 32'd9);
        check_results(tag, e_cnt, e_any, e_first, e_mask);
        @(negedge clk);
        check({tag, " done pulse width"}, 32'(done), 32'd0);
        check({tag, " idle after done"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (n < 20 && !done) begin
            @(negedge clk);
            n++;
        end
        if (!done) check({tag, " done timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        vec_t vecs[5];
        int dones;
        int r_cnt, r_first;
        logic [7:0] r_mask;

        vecs[0] = '{8'h00, 4, 1, 4, 8'hF0};
        vecs[1] = '{8'h0F, 1, 1, 4, 8'h10};
        vecs[2] = '{8'hF0, 0, 0, 0, 8'h00};
        vecs[3] = '{8'hAA, 0, 0, 0, 8'h00};
        vecs[4] = '{8'h87, 1, 1, 5, 8'h20};

        rst   = 1'b1;
        start = 1'b0;
        data  = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        for (int i = 0; i < 5; i++) begin
            run_word($sformatf("vec%0d", i), vecs[i].word, vecs[i].e_cnt,
                     vecs[i].e_any, vecs[i].e_first, vecs[i].e_mask);
        end
        check("results held in idle", 32'(first_idx), 32'd5);

        // FF run with start re-pulsed and data changed mid-run: must be ignored.
        @(negedge clk);
        start = 1'b1;
        data  = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        r_cnt = -1; r_first = -1; r_mask = 8'hxx;
        for (int c = 0; c < 16; c++) begin
            if (c == 2) begin start = 1'b1; data = 8'h00; end
            if (c == 3) start = 1'b0;
            if (done) begin
                dones++;
                r_cnt = int'(hit_cnt); r_first = int'(first_idx); r_mask = hit_mask;
            end
            @(negedge clk);
        end
        check("ff single done", 32'(dones), 32'd1);
        check("ff hit_cnt", 32'(r_cnt), 32'd4);
        check("ff first_idx", 32'(r_first), 32'd4);
        check("ff hit_mask", 32'(r_mask), 32'(mask_exp(8'hF0)));
        check("ff idle after", 32'(busy), 32'd0);

        // Reset asserted while idx 3 is on det_w.
        @(negedge clk);
        start = 1'b1;
        data  = 8'h00;
        @(posedge clk);
        #1 start = 1'b0;
        dones = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort mid-run busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("abort");
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort no done", 32'(dones), 32'd0);
        run_word("after abort", 8'h00, 4, 1, 4, 8'hF0);

        // start held high re-launches from IDLE one cycle after done.
        @(negedge clk);
        start = 1'b1;
        data  = 8'h0F;
        wait_done("held1");
        check_results("held1", 1, 1, 4, 8'h10);
        @(negedge clk);
        check("held idle gap", 32'(busy), 32'd0);
        @(negedge clk);
        check("held relaunch", 32'(busy), 32'd1);
        start = 1'b0;
        data  = 8'hAA;
        wait_done("held2");
        check_results("held2", 1, 1, 4, 8'h10);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
